// File: rtl/alu_wb.sv
// Write-back stage: one-entry pending register in front of an 8-bit register file and flags,
// with bypass of the pending entry onto the read ports and a wrapping retire counter.
module alu_wb #(
   parameter int NREG = 8,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [2:0]      ra_addr,
   input  logic [2:0]      rb_addr,
   output logic [7:0]      rd_a,
   output logic [7:0]      rd_b,
   output logic            sc_i,
   output logic            zero_f,
   output logic            pari_f,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_wen,
   input  logic [2:0]      in_waddr,
   input  logic [7:0]      in_rslt,
   input  logic            in_fwe,
   input  logic            in_sc,
   input  logic            in_zero,
   input  logic            in_pari,
   input  logic            hold,
   output logic            busy,
   output logic [CNTW-1:0] retire_cnt
);

   logic [7:0]      rf_q [NREG];
   logic [7:0]      rf_d [NREG];
   logic            carry_q, carry_d;
   logic            zero_q, zero_d;
   logic            pari_q, pari_d;
   logic            pv_q, pv_d;
   logic            p_wen_q, p_wen_d;
   logic [2:0]      p_waddr_q, p_waddr_d;
   logic [7:0]      p_rslt_q, p_rslt_d;
   logic            p_fwe_q, p_fwe_d;
   logic            p_sc_q, p_sc_d;
   logic            p_zero_q, p_zero_d;
   logic            p_pari_q, p_pari_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            accept;
   logic            commit;

   assign in_ready = rst_n && (!pv_q || !hold);
   assign accept   = in_valid && in_ready;
   assign commit   = pv_q && !hold && rst_n;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      rf_d      = rf_q;
      carry_d   = carry_q;
      zero_d    = zero_q;
      pari_d    = pari_q;
      cnt_d     = cnt_q;
      pv_d      = pv_q;
      p_wen_d   = p_wen_q;
      p_waddr_d = p_waddr_q;
      p_rslt_d  = p_rslt_q;
      p_fwe_d   = p_fwe_q;
      p_sc_d    = p_sc_q;
      p_zero_d  = p_zero_q;
      p_pari_d  = p_pari_q;

      if (commit) begin
         if (p_wen_q) rf_d[p_waddr_q] = p_rslt_q;
         if (p_fwe_q) begin
            carry_d = p_sc_q;
            zero_d  = p_zero_q;
            pari_d  = p_pari_q;
         end
         cnt_d = cnt_q + CNTW'(1);
         pv_d  = 1'b0;
      end

      // Accept after commit so a same-cycle reload keeps the entry valid.
      if (accept) begin
         pv_d      = 1'b1;
         p_wen_d   = in_wen;
         p_waddr_d = in_waddr;
         p_rslt_d  = in_rslt;
         p_fwe_d   = in_fwe;
         p_sc_d    = in_sc;
         p_zero_d  = in_zero;
         p_pari_d  = in_pari;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the register file is architecturally defined as zero after reset, so it is cleared here.
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b0;
         pari_q    <= 1'b0;
         cnt_q     <= '0;
         pv_q      <= 1'b0;
         p_wen_q   <= 1'b0;
         p_waddr_q <= '0;
         p_rslt_q  <= '0;
         p_fwe_q   <= 1'b0;
         p_sc_q    <= 1'b0;
         p_zero_q  <= 1'b0;
         p_pari_q  <= 1'b0;
      end else begin
         rf_q      <= rf_d;
         carry_q   <= carry_d;
         zero_q    <= zero_d;
         pari_q    <= pari_d;
         cnt_q     <= cnt_d;
         pv_q      <= pv_d;
         p_wen_q   <= p_wen_d;
         p_waddr_q <= p_waddr_d;
         p_rslt_q  <= p_rslt_d;
         p_fwe_q   <= p_fwe_d;
         p_sc_q    <= p_sc_d;
         p_zero_q  <= p_zero_d;
         p_pari_q  <= p_pari_d;
      end
   end

   // Pending entry bypasses onto reads, even while held.
   assign rd_a   = (pv_q && p_wen_q && p_waddr_q == ra_addr) ? p_rslt_q : rf_q[ra_addr];
   assign rd_b   = (pv_q && p_wen_q && p_waddr_q == rb_addr) ? p_rslt_q : rf_q[rb_addr];
   assign sc_i   = (pv_q && p_fwe_q) ? p_sc_q   : carry_q;
   assign zero_f = (pv_q && p_fwe_q) ? p_zero_q : zero_q;
   assign pari_f = (pv_q && p_fwe_q) ? p_pari_q : pari_q;

   assign busy       = pv_q;
   assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_alu_wb.sv
// Directed bench for alu_wb: reset, bypass, back-to-back throughput, hold, reset discard, counter wrap.
module tb_alu_wb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  ra_addr = '0, rb_addr = '0;
   logic [7:0]  rd_a, rd_b;
   logic        sc_i, zero_f, pari_f;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_wen = 1'b0;
   logic [2:0]  in_waddr = '0;
   logic [7:0]  in_rslt = '0;
   logic        in_fwe = 1'b0, in_sc = 1'b0, in_zero = 1'b0, in_pari = 1'b0;
   logic        hold = 1'b0;
   logic        busy;
   logic [15:0] retire_cnt;

   int total = 0;
   int bad = 0;

   alu_wb #(.NREG(8), .CNTW(16)) dut (
      .clk(clk), .rst_n(rst_n), .ra_addr(ra_addr), .rb_addr(rb_addr),
      .rd_a(rd_a), .rd_b(rd_b), .sc_i(sc_i), .zero_f(zero_f), .pari_f(pari_f),
      .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_waddr(in_waddr),
      .in_rslt(in_rslt), .in_fwe(in_fwe), .in_sc(in_sc), .in_zero(in_zero),
      .in_pari(in_pari), .hold(hold), .busy(busy), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic wen, input logic [2:0] wa, input logic [7:0] r,
                        input logic fwe, input logic sc, input logic z, input logic p);
      in_valid = 1'b1; in_wen = wen; in_waddr = wa; in_rslt = r;
      in_fwe = fwe; in_sc = sc; in_zero = z; in_pari = p;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; hold = 1'b0; in_valid = 1'b1;
      tick(); tick();
      ra_addr = 3'd3; rb_addr = 3'd7; #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %0b want 0", in_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
      total++; if (retire_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", retire_cnt); end
      total++; if (rd_a !== 8'h00 || rd_b !== 8'h00) begin bad++; $display("FAIL reset_rd: got %0h/%0h want 0/0", rd_a, rd_b); end
      total++; if ({sc_i, zero_f, pari_f} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {sc_i, zero_f, pari_f}); end
      in_valid = 1'b0;
      rst_n = 1'b1; #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_rel: got %0b want 1", in_ready); end
   endtask

   task automatic test_single();
      ra_addr = 3'd3; rb_addr = 3'd3;
      offer(1'b1, 3'd3, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0; #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %0b want 1", busy); end
      total++; if (rd_a !== 8'hA5) begin bad++; $display("FAIL single_bypass: got %0h want a5", rd_a); end
      total++; if (retire_cnt !== 16'd0) begin bad++; $display("FAIL single_cnt0: got %0d want 0", retire_cnt); end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got %0b want 0", busy); end
      total++; if (rd_a !== 8'hA5 || rd_b !== 8'hA5) begin bad++; $display("FAIL single_rf: got %0h/%0h want a5/a5", rd_a, rd_b); end
      total++; if (retire_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt1: got %0d want 1", retire_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] wa [4] = '{3'd1, 3'd2, 3'd3, 3'd1};
      logic [7:0] rv [4] = '{8'h01, 8'h02, 8'h03, 8'hFF};
      ra_addr = 3'd1;
      for (int i = 0; i < 4; i++) begin
         offer(1'b1, wa[i], rv[i], 1'b0, 1'b0, 1'b0, 1'b0); #1;
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %0b want 1", i, in_ready); end
         tick();
      end
      in_valid = 1'b0; #1;
      // R1=01 is committed, R1=FF still pending: read must see FF.
      total++; if (rd_a !== 8'hFF) begin bad++; $display("FAIL b2b_bypass: got %0h want ff", rd_a); end
      total++; if (retire_cnt !== 16'd4) begin bad++; $display("FAIL b2b_cnt_mid: got %0d want 4", retire_cnt); end
      tick();
      ra_addr = 3'd1; rb_addr = 3'd2; #1;
      total++; if (retire_cnt !== 16'd5) begin bad++; $display("FAIL b2b_cnt: got %0d want 5", retire_cnt); end
      total++; if (rd_a !== 8'hFF || rd_b !== 8'h02) begin bad++; $display("FAIL b2b_rf12: got %0h/%0h want ff/02", rd_a, rd_b); end
      ra_addr = 3'd3; #1;
      total++; if (rd_a !== 8'h03 || busy !== 1'b0) begin bad++; $display("FAIL b2b_rf3: got %0h busy %0b want 03 busy 0", rd_a, busy); end
   endtask

   task automatic test_flags_hold();
      offer(1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if ({sc_i, zero_f, pari_f} !== 3'b110) begin bad++; $display("FAIL hold_flags%0d: got %b want 110", i, {sc_i, zero_f, pari_f}); end
         total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL hold_ready%0d: got rdy %0b busy %0b want 0 1", i, in_ready, busy); end
         total++; if (retire_cnt !== 16'd5) begin bad++; $display("FAIL hold_cnt%0d: got %0d want 5", i, retire_cnt); end
         tick();
      end
      hold = 1'b0; in_valid = 1'b0;
      tick();
      total++; if (retire_cnt !== 16'd6 || busy !== 1'b0) begin bad++; $display("FAIL hold_commit: got cnt %0d busy %0b want 6 0", retire_cnt, busy); end
      total++; if ({sc_i, zero_f, pari_f} !== 3'b110) begin bad++; $display("FAIL hold_flags_arch: got %b want 110", {sc_i, zero_f, pari_f}); end
   endtask

   task automatic test_nop();
      ra_addr = 3'd1;
      offer(1'b0, 3'd1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      total++; if (rd_a !== 8'hFF) begin bad++; $display("FAIL nop_rf: got %0h want ff", rd_a); end
      total++; if ({sc_i, zero_f, pari_f} !== 3'b110) begin bad++; $display("FAIL nop_flags: got %b want 110", {sc_i, zero_f, pari_f}); end
      total++; if (retire_cnt !== 16'd7) begin bad++; $display("FAIL nop_cnt: got %0d want 7", retire_cnt); end
   endtask

   task automatic test_hold_empty();
      ra_addr = 3'd6;
      hold = 1'b1;
      offer(1'b1, 3'd6, 8'h6B, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hempty_ready: got %0b want 1", in_ready); end
      tick();
      in_valid = 1'b0;
      tick();
      total++; if (busy !== 1'b1 || retire_cnt !== 16'd7 || rd_a !== 8'h6B) begin bad++; $display("FAIL hempty_wait: got busy %0b cnt %0d rd %0h want 1 7 6b", busy, retire_cnt, rd_a); end
      hold = 1'b0;
      tick();
      total++; if (busy !== 1'b0 || retire_cnt !== 16'd8 || rd_a !== 8'h6B) begin bad++; $display("FAIL hempty_commit: got busy %0b cnt %0d rd %0h want 0 8 6b", busy, retire_cnt, rd_a); end
   endtask

   task automatic test_reset_discard();
      ra_addr = 3'd5; rb_addr = 3'd1;
      offer(1'b1, 3'd5, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      in_valid = 1'b0; hold = 1'b1; #1;
      total++; if (rd_a !== 8'h3C || busy !== 1'b1) begin bad++; $display("FAIL discard_pend: got %0h busy %0b want 3c 1", rd_a, busy); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; hold = 1'b0;
      tick();
      total++; if (rd_a !== 8'h00 || rd_b !== 8'h00) begin bad++; $display("FAIL discard_rf: got %0h/%0h want 0/0", rd_a, rd_b); end
      total++; if (retire_cnt !== 16'd0 || busy !== 1'b0) begin bad++; $display("FAIL discard_state: got cnt %0d busy %0b want 0 0", retire_cnt, busy); end
      total++; if ({sc_i, zero_f, pari_f} !== 3'b000) begin bad++; $display("FAIL discard_flags: got %b want 000", {sc_i, zero_f, pari_f}); end
   endtask

   task automatic test_wrap();
      // 65535 edges with in_valid high plus one drain edge retire 65535 entries.
      offer(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 65535; i++) tick();
      in_valid = 1'b0;
      tick();
      total++; if (retire_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_max: got %0h want ffff", retire_cnt); end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      total++; if (retire_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %0h want 0", retire_cnt); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_flags_hold();
      test_nop();
      test_hold_empty();
      test_reset_discard();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
